// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper and its interface.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;

  function automatic int unsigned sweep_len(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic int unsigned tt_width(input int unsigned n_in, input int unsigned n_out);
    return sweep_len(n_in) * n_out;
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Handshake/result bundle between a sweep host (master) and tt_sweep_checker (slave).
interface tt_sweep_checker_if
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1
);

  localparam int unsigned TT_W = tt_width(N_IN, N_OUT);

  logic              start;
  logic [TT_W-1:0]   expected_tt;
  logic [N_OUT-1:0]  dut_out;
  logic [N_IN-1:0]   dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_fail_idx;
  logic              first_fail_valid;

  modport master (
    output start, expected_tt, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );

  modport slave (
    input  start, expected_tt, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );

endinterface

// File: rtl/tt_sweep_checker_hold_timer.sv
// Free-running HOLD-cycle counter with synchronous clear; o_last marks the final hold cycle.
module tt_hold_timer #(
  parameter int unsigned HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_last
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CW-1:0] r_cnt;

  assign o_last = (r_cnt == CW'(HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Self-sequencing truth-table sweeper: applies every input vector, compares, reports.
// Optional TT_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned HOLD  = 2
) (
  input logic               clk,
  input logic               rst,
  tt_sweep_checker_if.slave bus
);

  localparam int unsigned N_VEC = sweep_len(N_IN);

  sweep_state_t      r_state;
  logic [N_IN-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [N_IN:0]     r_err;
  logic [N_IN-1:0]   r_ff_idx;
  logic              r_ff_valid;

  logic              w_last_hold;
  logic              w_mismatch;
  logic              w_last_vec;
  logic              w_finish;
  logic [N_OUT-1:0]  w_exp;
  logic [N_IN:0]     w_err_next;

  tt_hold_timer #(.HOLD(HOLD)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state != ST_APPLY),
    .i_en    (r_state == ST_APPLY),
    .o_last  (w_last_hold)
  );

  // Constant-base slice select keeps the table lookup a plain mux.
  always_comb begin
    w_exp = '0;
    for (int unsigned v = 0; v < N_VEC; v++) begin
      if (r_vec == N_IN'(v)) w_exp = bus.expected_tt[v*N_OUT +: N_OUT];
    end
  end

  // Case inequality so any X/Z on the DUT response is a failure.
  assign w_mismatch = (bus.dut_out !== w_exp);
  assign w_last_vec = &r_vec;
  assign w_err_next = r_err + {{N_IN{1'b0}}, w_mismatch};

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
  assign w_finish = w_last_vec || w_mismatch;
`else
  assign w_finish = w_last_vec;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_ff_idx   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_APPLY;
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_ff_idx   <= '0;
            r_ff_valid <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (w_last_hold) begin
            r_err <= w_err_next;
            if (w_mismatch && !r_ff_valid) begin
              r_ff_idx   <= r_vec;
              r_ff_valid <= 1'b1;
            end
            if (w_finish) begin
              r_state <= ST_DONE;
              r_vec   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_vec <= r_vec + N_IN'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_in           = r_vec;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_count        = r_err;
  assign bus.first_fail_idx   = r_ff_idx;
  assign bus.first_fail_valid = r_ff_valid;

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Parametrised, self-sequencing truth-table sweeper for checking combinational lab circuits in hardware or simulation.
- On `start`, drives every N_IN-bit input combination to a combinational DUT in ascending order and holds each for HOLD cycles.
- Compares the DUT response against a supplied expected truth table and reports the result.
- Replaces hand-written per-vector stimulus lists with one reusable block that benches and FPGA top-levels instantiate next to the DUT.

Parameters:
- N_IN, 4, DUT input width; sweep covers 2^N_IN vectors (1..8).
- N_OUT, 1, DUT output width (1..8).
- HOLD, 2, cycles each vector is applied (>=1); sampling happens on the last hold cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- expected_tt  in  (2^N_IN)*N_OUT  expected outputs; vector v at bits [v*N_OUT +: N_OUT]; must be static during a sweep.
- dut_out  in  N_OUT  DUT response.
- dut_in  out  N_IN  vector applied to the DUT.
- busy  out  1  high while the sweep is in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  high when the last completed sweep had zero mismatches.
- err_count  out  N_IN+1  mismatches in the last sweep.
- first_fail_idx  out  N_IN  index of the first mismatching vector.
- first_fail_valid  out  1  first_fail_idx is meaningful.

Behaviour:
- Reset (async, any state): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 at an edge -> APPLY. Vector and hold counters clear; err_count, first_fail_* and pass clear.
- APPLY:
  - busy=1; dut_in=vector counter.
  - Hold counter counts 0..HOLD-1.
  - At the edge ending hold count HOLD-1:
    - Compare dut_out against expected_tt slice; on mismatch, err_count+1.
    - If this is the first mismatch, latch first_fail_idx=vector and set first_fail_valid=1.
    - If vector = 2^N_IN-1 -> DONE; otherwise vector+1 and hold counter resets.
- DONE:
  - One cycle: done=1, busy=0, dut_in=0.
  - pass = (err_count==0), evaluated with the final compare included.
  - Always -> IDLE.
- Result hold: pass, err_count and first_fail_* stay stable until the next accepted start or reset.
- Latency: start accepted at edge k -> done high in the cycle after edge k + 2^N_IN*HOLD.
  - Default parameters: 33 cycles.
- Boundary conditions:
  - start while in APPLY or DONE is ignored; there is no queueing.
  - err_count never overflows; its maximum is 2^N_IN.
  - Vector counter stops at the final vector and does not wrap into a new sweep.
  - rst mid-sweep aborts immediately to reset values; no done pulse.
  - HOLD=1: every APPLY cycle is a compare cycle.
  - Any X on dut_out counts as a mismatch (case-inequality compare).

Optional Feature:
- Macro: TT_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch sends APPLY -> DONE at that compare edge. Result is err_count=1, pass=0 and first_fail_* set; remaining vectors are not applied.
- Undefined: the full sweep always runs and err_count totals all mismatches.

Decomposition:
- Package tt_sweep_pkg holds:
  - the FSM state encoding constants (IDLE/APPLY/DONE);
  - a function returning the truth-table width (2^N_IN)*N_OUT;
  - a function returning the sweep length 2^N_IN.
- Sub-module tt_hold_timer: HOLD-cycle counter with clear input and last-cycle strobe output; reused by other lab sequencers.

Test Plan:
1. Parity DUT: N_IN=4, N_OUT=1, HOLD=2, expected_tt=16'h6996. Pulse start -> dut_in steps 0..15, 2 cycles each; done 33 cycles after start; pass=1, err_count=0, first_fail_valid=0.
2. Same setup with the DUT output inverted only for vector 5 -> err_count=1, first_fail_idx=5, first_fail_valid=1, pass=0. Add a second fault at 12 -> err_count=2, first_fail_idx stays 5.
3. AND gate: N_IN=2, HOLD=1, expected_tt=4'b1000 -> done 5 cycles after start, pass=1. Stuck-at-0 DUT -> err_count=1, first_fail_idx=3.
4. Assert rst while dut_in=7 (mid-hold) -> all outputs at reset values in the same cycle, no done. A new start then completes a full 33-cycle sweep.
5. start held high throughout a sweep -> exactly one sweep per IDLE visit. start pulses during APPLY do not restart the sweep or alter dut_in.
6. TT_SWEEP_STOP_ON_FAIL_EN defined, fault at vector 3, HOLD=2 -> done 9 cycles after start, dut_in never exceeds 3, err_count=1.
